// File: rtl/piso_tx.sv
// piso_tx: parallel-in, serial-out transmitter.
//
// Loads a WIDTH-bit word when idle and i_Valid is high, then shifts it out on
// o_Serial one bit at a time, each bit held CLKS_PER_BIT clocks. A single DONE
// cycle follows every completed frame before the block returns to IDLE.
//
// Parameters:
//   WIDTH        bits per frame (>= 2)
//   CLKS_PER_BIT clocks each bit is held (>= 1)
//   MSB_FIRST    1: bit WIDTH-1 goes first, 0: bit 0 goes first
//
// Ports:
//   i_CLK    clock, rising edge
//   i_RST    synchronous active-high reset
//   i_Data   parallel word, captured only on acceptance
//   i_Valid  load/start request, level-sensitive
//   o_Ready  high in IDLE
//   o_Serial current serial bit (0 outside a frame)
//   o_Frame  high while o_Serial carries a frame bit
//   o_Done   one-cycle pulse after the last bit of a frame
//
// All outputs are registered; none depends combinationally on an input.

module piso_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Valid,
    output logic             o_Ready,
    output logic             o_Serial,
    output logic             o_Frame,
    output logic             o_Done
);

    localparam int unsigned BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("piso_tx: WIDTH must be >= 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
        $error("piso_tx: CLKS_PER_BIT must be >= 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [CYC_W-1:0] cyc_cnt_q;
    logic [WIDTH-1:0] shift_next;

    // Bit that leaves the register first for a given word.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Register contents after moving on to the next bit.
    always_comb begin
        shift_next = '0;
        if (MSB_FIRST != 0) begin
            shift_next = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_next = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    // o_Serial is loaded with the lead bit of whatever the register will hold
    // next, so it always mirrors the register's outgoing bit without a
    // combinational path.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cyc_cnt_q <= '0;
            o_Ready   <= 1'b1;
            o_Frame   <= 1'b0;
            o_Serial  <= 1'b0;
            o_Done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_Valid) begin
                        state_q   <= StShift;
                        shift_q   <= i_Data;
                        bit_cnt_q <= '0;
                        cyc_cnt_q <= '0;
                        o_Ready   <= 1'b0;
                        o_Frame   <= 1'b1;
                        o_Serial  <= lead_bit(i_Data);
                    end
                end

                StShift: begin
                    if (cyc_cnt_q == CYC_LAST) begin
                        cyc_cnt_q <= '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q  <= StDone;
                            o_Frame  <= 1'b0;
                            o_Serial <= 1'b0;
                            o_Done   <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            shift_q   <= shift_next;
                            o_Serial  <= lead_bit(shift_next);
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + CYC_W'(1);
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                    o_Done  <= 1'b0;
                    o_Ready <= 1'b1;
                end

                default: begin
                    state_q  <= StIdle;
                    o_Ready  <= 1'b1;
                    o_Frame  <= 1'b0;
                    o_Serial <= 1'b0;
                    o_Done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three instances (MSB-first/4 clk, LSB-first/2 clk,
// MSB-first/1 clk) share one stimulus stream. A frame-timeline model checks
// every output of every instance on every falling edge; directed sections
// pin the model with hand-computed literal sequences.

module tb_piso_tx;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;

    logic [2:0] ready, serial, frame, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1)) u0 (
        .i_CLK(clk), .i_RST(rst), .i_Data(data), .i_Valid(valid),
        .o_Ready(ready[0]), .o_Serial(serial[0]), .o_Frame(frame[0]), .o_Done(done[0])
    );
    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(2), .MSB_FIRST(0)) u1 (
        .i_CLK(clk), .i_RST(rst), .i_Data(data), .i_Valid(valid),
        .o_Ready(ready[1]), .o_Serial(serial[1]), .o_Frame(frame[1]), .o_Done(done[1])
    );
    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) u2 (
        .i_CLK(clk), .i_RST(rst), .i_Data(data), .i_Valid(valid),
        .o_Ready(ready[2]), .o_Serial(serial[2]), .o_Frame(frame[2]), .o_Done(done[2])
    );

    function automatic int cpb(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit msb_first(input int i);
        return (i != 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, whether a frame is in flight, the captured word,
    // and cycles elapsed since acceptance. Cycles 0..W*C-1 are frame bits,
    // cycle W*C is DONE, after which the instance is idle again.
    bit         started = 1'b0;
    bit         busy [3];
    int         pos  [3];
    logic [7:0] word [3];

    always @(posedge clk) begin
        if (rst) started <= 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                busy[i] <= 1'b0;
                pos[i]  <= 0;
            end else if (!busy[i]) begin
                if (valid) begin
                    busy[i] <= 1'b1;
                    pos[i]  <= 0;
                    word[i] <= data;
                end
            end else if (pos[i] >= W * cpb(i)) begin
                busy[i] <= 1'b0;
            end else begin
                pos[i] <= pos[i] + 1;
            end
        end
    end

    // {ready, frame, serial, done}
    function automatic logic [3:0] model_out(input int i);
        int k;
        if (!busy[i]) return 4'b1000;
        if (pos[i] < W * cpb(i)) begin
            k = pos[i] / cpb(i);
            return {1'b0, 1'b1, msb_first(i) ? word[i][W-1-k] : word[i][k], 1'b0};
        end
        return 4'b0001;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_u%0d", i), {ready[i], frame[i], serial[i], done[i]},
                    model_out(i));
            end
        end
    end

    bit lit_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit lit_c1 [8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    bit lit_3c [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    bit lit_5a [8] = '{0, 1, 0, 1, 1, 0, 1, 0};

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h00;

        // Reset held with valid high: nothing may start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_prio_ready", ready[0], 1'b1);
            chk("rst_prio_frame", frame[0], 1'b0);
        end
        rst  = 1'b0;
        data = 8'hA5;
        @(negedge clk);
        chk("first_after_rst", frame[0], 1'b1);
        valid = 1'b0;

        // 0xA5, MSB first, 4 clocks per bit.
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            chk("a5_frame", frame[0], 1'b1);
            chk("a5_serial", serial[0], lit_a5[i/4]);
        end
        @(negedge clk);
        chk("a5_done", done[0], 1'b1);
        chk("a5_done_frame", frame[0], 1'b0);
        @(negedge clk);
        chk("a5_ready", ready[0], 1'b1);
        chk("a5_done_low", done[0], 1'b0);

        // 0xC1, LSB first, 2 clocks per bit.
        do_reset();
        data  = 8'hC1;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            chk("c1_serial", serial[1], lit_c1[k/2]);
        end
        @(negedge clk);
        chk("c1_done", done[1], 1'b1);

        // Request while busy is dropped.
        do_reset();
        data  = 8'h00;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            chk("busy_serial", serial[0], 1'b0);
            if (i == 12) begin
                valid = 1'b1;
                data  = 8'hFF;
            end else if (i == 13) begin
                valid = 1'b0;
                data  = 8'h00;
            end
        end
        @(negedge clk);
        chk("busy_done", done[0], 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("busy_no_restart", {ready[0], frame[0]}, 2'b10);
        end

        // Reset mid-frame at bit 5; data changed after acceptance.
        do_reset();
        data  = 8'hA5;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            chk("abort_serial", serial[0], lit_a5[i/4]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_frame", frame[0], 1'b0);
        chk("abort_ready", ready[0], 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_no_done", done[0], 1'b0);
        end

        // Back-to-back at 1 clock per bit with valid held high.
        do_reset();
        data  = 8'h3C;
        valid = 1'b1;
        @(negedge clk);
        data = 8'h5A;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 8) begin
                chk("b2b_f1", {frame[2], serial[2]}, {1'b1, lit_3c[i]});
            end else if (i == 8) begin
                chk("b2b_done1", {frame[2], done[2]}, 2'b01);
            end else if (i == 9) begin
                chk("b2b_idle", {ready[2], frame[2]}, 2'b10);
            end else if (i < 18) begin
                chk("b2b_f2", {frame[2], serial[2]}, {1'b1, lit_5a[i-10]});
            end else begin
                chk("b2b_done2", {frame[2], done[2]}, 2'b01);
            end
        end
        valid = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            valid = ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
        end
        rst   = 1'b0;
        valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
